// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared opcodes, FSM states and instruction field positions
// Contents: opcode constants shared with the ALU, issue FSM state enum,
// instruction field bit positions, register-file geometry, opcode classifier.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_ERR
  } state_t;

  // Opcodes that go through the ALU (everything decodable except LDI).
  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8-entry register file, two async read ports, debug read, one sync write
// Ports: clk, rst (sync clear of all entries), we/waddr/wdata write port,
// raddr_a/rdata_a and raddr_b/rdata_b operand reads, dbg_addr/dbg_data debug read.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue instruction controller driving an external registered ALU
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready/instr instruction handshake;
// alu_en/alu_oe/alu_opcode/alu_a/alu_b to the ALU; alu_out and cf_in/of_in/sf_in/zf_in from it;
// done (write-back pulse), illegal (bad opcode pulse), flags {CF,OF,SF,ZF};
// dbg_addr/dbg_data combinational register-file read.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              alu_en,
  output logic              alu_oe,
  output logic [3:0]        alu_opcode,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              cf_in,
  input  logic              of_in,
  input  logic              sf_in,
  input  logic              zf_in,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  state_t state, state_nxt;

  logic              accept;
  logic [3:0]        in_opcode;
  logic [3:0]        opcode_q;
  logic [REG_AW-1:0] rd_q;
  logic [7:0]        imm_q;
  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic [WIDTH-1:0]  wb_data;

  assign in_opcode = instr[OPC_MSB:OPC_LSB];
  assign alu_oe    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // done/illegal are gated by rst so a reset landing in WB or ERR also
  // cancels the pulse and the register write it qualifies.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        if (instr_valid) begin
          if (is_alu_op(in_opcode)) begin
            state_nxt = ST_EXEC;
          end else if (in_opcode == OP_LDI) begin
            state_nxt = ST_WB;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        done      = ~rst;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        illegal   = ~rst;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU drive is registered at the accept edge, so alu_en is high exactly
  // during EXEC and the operand/opcode outputs hold until the next ALU op.
  // Operands are read at accept, before any write-back of this instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q   <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_en     <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      flags      <= '0;
    end else begin
      alu_en <= 1'b0;
      if (accept) begin
        opcode_q <= in_opcode;
        rd_q     <= instr[RD_MSB:RD_LSB];
        imm_q    <= instr[IMM_MSB:IMM_LSB];
        if (is_alu_op(in_opcode)) begin
          alu_en     <= 1'b1;
          alu_opcode <= in_opcode;
          alu_a      <= rs1_data;
          alu_b      <= rs2_data;
        end
      end
      if (done && (opcode_q != OP_LDI)) begin
        flags <= {cf_in, of_in, sf_in, zf_in};
      end
    end
  end

  assign wb_data = (opcode_q == OP_LDI) ? WIDTH'(imm_q) : alu_out;

  alu_regfile #(
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (done),
    .waddr    (rd_q),
    .wdata    (wb_data),
    .raddr_a  (instr[RS1_MSB:RS1_LSB]),
    .rdata_a  (rs1_data),
    .raddr_b  (instr[RS2_MSB:RS2_LSB]),
    .rdata_b  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, datapath width; SHALL match the WIDTH of the ALU it drives.
REQ-002 CLK  in  1  single clock; all state SHALL update on posedge CLK only.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 INSTR_VALID  in  1  instruction word present.
REQ-005 INSTR_READY  out  1  block can accept an instruction this cycle.
REQ-006 INSTR  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only).
REQ-007 ALU_EN, ALU_OE  out  1 each  ALU enable and output enable.
REQ-008 ALU_OPCODE  out  4  opcode to ALU.
REQ-009 ALU_A, ALU_B  out  WIDTH  operands to ALU.
REQ-010 ALU_OUT  in  WIDTH  registered ALU result.
REQ-011 CF_IN, OF_IN, SF_IN, ZF_IN  in  1 each  ALU flags.
REQ-012 DONE  out  1  one-cycle pulse on register write-back.
REQ-013 ILLEGAL  out  1  one-cycle pulse on undecodable opcode.
REQ-014 FLAGS  out  4  architectural flags {CF,OF,SF,ZF}.
REQ-015 DBG_ADDR  in  3 / DBG_DATA  out  WIDTH  combinational register-file read port.

Function
REQ-016 Opcodes: 0001 LDI, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT (uses rs1 only); all others illegal.
REQ-017 Register file SHALL be 8 x WIDTH; r0 is an ordinary register.
REQ-018 FSM states SHALL be IDLE, EXEC, WB, ERR.
REQ-019 INSTR_READY SHALL be 1 only in IDLE; an instruction is accepted on an edge with INSTR_VALID && INSTR_READY; INSTR SHALL be latched at acceptance.
REQ-020 IDLE transitions on accept: ALU opcode -> EXEC; LDI -> WB; illegal -> ERR; otherwise stay IDLE.
REQ-021 EXEC (1 cycle): ALU_EN=1, ALU_OPCODE=latched opcode, ALU_A=rf[rs1], ALU_B=rf[rs2]; then -> WB.
REQ-022 In all states other than EXEC, ALU_EN SHALL be 0 and ALU_A/ALU_B/ALU_OPCODE SHALL hold their last values.
REQ-023 ALU_OE SHALL be constant 1.
REQ-024 WB (1 cycle): DONE=1; at the edge ending WB, rf[rd] <= ALU_OUT (ALU op) or imm[WIDTH-1:0] zero-extended (LDI); then -> IDLE.
REQ-025 WB of an ALU op SHALL also latch FLAGS <= {CF_IN,OF_IN,SF_IN,ZF_IN}; LDI SHALL leave FLAGS unchanged.
REQ-026 ERR (1 cycle): ILLEGAL=1, no register or flag write, ALU_EN=0; then -> IDLE.
REQ-027 Throughput: ALU op 3 cycles accept-to-accept, LDI 2, illegal 2; DONE asserts 2 cycles after ALU-op accept edge, 1 cycle after LDI accept edge.
REQ-028 rd == rs1/rs2 SHALL read the pre-write value (operands sampled in EXEC before WB write).
REQ-029 DBG_DATA SHALL reflect a WB write starting the cycle after the write edge.
REQ-030 INSTR_VALID during non-IDLE states SHALL be ignored and not stalled into later acceptance other than via normal handshake.

Reset
REQ-031 RST high at an edge SHALL force: state IDLE, all rf entries 0, FLAGS 0, DONE 0, ILLEGAL 0, ALU_EN 0, ALU_A/ALU_B 0, ALU_OPCODE 0, ALU_OE 1.
REQ-032 RST SHALL take priority over accept and write-back; reset in EXEC or WB SHALL suppress the pending write and DONE.
REQ-033 INSTR_READY SHALL be 1 in the first cycle after RST deasserts.

Structure
REQ-034 Shared package SHALL hold opcode constants (shared with the ALU), state enum, and instruction field bit positions.
REQ-035 Register file SHALL be a sub-module alu_regfile (2 async read ports + debug read port, 1 sync write port, sync clear).

Verification
REQ-036 Reset, then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> DBG r3=0x08, DONE 2 cycles after ADD accept, FLAGS CF=0,OF=0.
REQ-037 With r1=0x05, r2=0x03: SUB r4,r2,r1 -> r4=0xFE, FLAGS CF=1 as delivered by ALU.
REQ-038 INSTR opcode 0xF -> ILLEGAL pulse 1 cycle after accept, all regs and FLAGS unchanged, ALU_EN never 1.
REQ-039 INSTR_VALID held high with ADD,ADD,LDI stream -> accepts at cycles 0,3,6; INSTR_READY low in between.
REQ-040 RST asserted during EXEC of ADD r3 -> r3=0x00, DONE never pulses, INSTR_READY=1 the cycle after RST drops.
REQ-041 ADD r1,r1,r1 with r1=0x80 -> r1=0x00, carry from ALU latched into FLAGS CF=1.
